gate_truth_table_scanner: RTL and testbench

Sequential stimulus-and-capture stage that wraps a 2-input decoder-based gate. It drives the gate's a/b inputs through all four combinations 00→11, samples the gate output for each, and assembles a 4-bit truth table. It then compares the table against an expected table latched at start and reports pass/fail. It sits directly upstream of the gate (feeds a, b) and consumes the gate's single-bit output.

---
 rtl/gate_truth_table_scanner.sv | 109 ++++++++++
 tb/tb_gate_truth_table_scanner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_scanner.sv
// Drives a 2-input gate through {a,b} = 00..11, captures its output into a
// 4-bit truth table, and compares it against an expected table latched at start.
module gate_truth_table_scanner #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exp_tt,
  input  logic       gate_in,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] tt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  // Out-of-range settings are pinned to the nearest value the 4-bit counter supports.
  localparam int SETTLE_CLAMPED = (SETTLE_CYCLES < 1)  ? 1  :
                                  (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CLAMPED - 1);

  state_t     state_reg;
  logic [1:0] idx_reg;
  logic [3:0] cnt_reg;
  logic [3:0] exp_reg;
  logic       accept_start;

  assign accept_start = (state_reg == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= 2'd0;
      cnt_reg   <= 4'd0;
      exp_reg   <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          a <= 1'b0;
          b <= 1'b0;
          if (start) begin
            exp_reg   <= exp_tt;
            idx_reg   <= 2'd0;
            cnt_reg   <= 4'd0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state_reg <= DRIVE;
          end
        end
        DRIVE: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == SETTLE_LAST) begin
            state_reg <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (idx_reg == 2'd3) begin
            a         <= 1'b0;
            b         <= 1'b0;
            state_reg <= CHECK;
          end else begin
            // Present the next vector on the same edge that advances the index.
            {a, b}    <= idx_reg + 2'd1;
            idx_reg   <= idx_reg + 2'd1;
            cnt_reg   <= 4'd0;
            state_reg <= DRIVE;
          end
        end
        CHECK: begin
          pass      <= (tt == exp_reg);
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Each table bit is captured only in the SAMPLE cycle of its own vector.
  for (genvar gi = 0; gi < 4; gi++) begin : g_tt_bit
    logic capture_en;
    assign capture_en = (state_reg == SAMPLE) && (idx_reg == 2'(gi));

    always_ff @(posedge clk) begin
      if (rst || accept_start) begin
        tt[gi] <= 1'b0;
      end else if (capture_en) begin
        tt[gi] <= gate_in;
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_table_scanner.sv
// Bench for gate_truth_table_scanner: two instances (SETTLE_CYCLES 2 and 1)
// each driven by a truth-table gate model, checked cycle by cycle.
module tb_gate_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [2];
  logic [3:0] exp_s   [2];
  logic [3:0] fn_s    [2];
  logic       noise_s [2];
  logic       gate_s  [2];
  logic       a_s     [2];
  logic       b_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [3:0] tt_s    [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Gate model: output is the function table indexed by {a,b}, optionally corrupted.
  assign gate_s[0] = fn_s[0][{a_s[0], b_s[0]}] ^ noise_s[0];
  assign gate_s[1] = fn_s[1][{a_s[1], b_s[1]}] ^ noise_s[1];

  gate_truth_table_scanner #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .exp_tt(exp_s[0]), .gate_in(gate_s[0]),
    .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .tt(tt_s[0])
  );

  gate_truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .exp_tt(exp_s[1]), .gate_in(gate_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .tt(tt_s[1])
  );

  typedef struct {
    logic [3:0] fn;
    logic [3:0] exp;
    logic [3:0] tt_want;
    logic       pass_want;
    int         start_at;
    string      tag;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Full scan from the current time (start raised now, accepted at the next edge E0).
  // Expected behaviour is derived from cycle offset n after E0.
  task automatic run_scan(input int d, input logic [3:0] fn, input logic [3:0] exp,
                          input logic [3:0] tt_want, input logic pass_want,
                          input bit noise_en, input int start_at, input string tag);
    int s;
    int per;
    int last;
    logic [3:0] mask;
    logic [1:0] ab_want;
    s    = (d == 0) ? 2 : 1;
    per  = s + 1;
    last = 4 * per + 1;
    fn_s[d]    = fn;
    exp_s[d]   = exp;
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    exp_s[d]   = ~exp;
    for (int n = 0; n <= last; n++) begin
      mask = 4'b0000;
      for (int k = 0; k < 4; k++) if (n >= (k + 1) * per) mask[k] = 1'b1;
      ab_want = (n < 4 * per) ? 2'(n / per) : 2'd0;
      chk({tag, ".ab"},   {6'd0, a_s[d], b_s[d]}, {6'd0, ab_want});
      chk({tag, ".busy"}, {7'd0, busy_s[d]}, {7'd0, (n < last)});
      chk({tag, ".done"}, {7'd0, done_s[d]}, {7'd0, (n == last)});
      chk({tag, ".pass"}, {7'd0, pass_s[d]}, {7'd0, (n == last) ? pass_want : 1'b0});
      chk({tag, ".tt"},   {4'd0, tt_s[d]},   {4'd0, tt_want & mask});
      if (n == last) break;
      start_s[d] = (n == start_at - 1);
      if (start_s[d]) exp_s[d] = 4'($urandom);
      noise_s[d] = (noise_en && ((n % per) != s)) ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
    end
    noise_s[d] = 1'b0;
    start_s[d] = 1'b0;
    $display("scan %s dut%0d fn=%b exp=%b -> tt=%b pass=%b", tag, d, fn, exp, tt_s[d], pass_s[d]);
  endtask

  vec_t vecs [4];

  initial begin
    logic [3:0] fn;
    logic [3:0] exp;
    int d;

    vecs[0] = '{fn: 4'b1110, exp: 4'b1110, tt_want: 4'b1110, pass_want: 1'b1, start_at: -1, tag: "or"};
    vecs[1] = '{fn: 4'b1000, exp: 4'b1110, tt_want: 4'b1000, pass_want: 1'b0, start_at: -1, tag: "and"};
    vecs[2] = '{fn: 4'b0111, exp: 4'b0111, tt_want: 4'b0111, pass_want: 1'b1, start_at: 5,  tag: "nand_busy_start"};
    vecs[3] = '{fn: 4'b0110, exp: 4'b1001, tt_want: 4'b0110, pass_want: 1'b0, start_at: 9,  tag: "xor"};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; exp_s[i] = 4'hF; fn_s[i] = 4'hF; noise_s[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset.ab",   {6'd0, a_s[i], b_s[i]}, 8'd0);
      chk("reset.busy", {7'd0, busy_s[i]}, 8'd0);
      chk("reset.done", {7'd0, done_s[i]}, 8'd0);
      chk("reset.pass", {7'd0, pass_s[i]}, 8'd0);
      chk("reset.tt",   {4'd0, tt_s[i]},   8'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_scan(0, vecs[i].fn, vecs[i].exp, vecs[i].tt_want, vecs[i].pass_want, 1'b0,
               vecs[i].start_at, vecs[i].tag);
      @(posedge clk); #1;
    end

    // Reset in the middle of a scan: outputs return to reset values, no done pulse.
    fn_s[0] = 4'b1110; exp_s[0] = 4'b1110; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst.busy_before", {7'd0, busy_s[0]}, 8'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.ab",   {6'd0, a_s[0], b_s[0]}, 8'd0);
    chk("midrst.busy", {7'd0, busy_s[0]}, 8'd0);
    chk("midrst.pass", {7'd0, pass_s[0]}, 8'd0);
    chk("midrst.tt",   {4'd0, tt_s[0]},   8'd0);
    chk("midrst.done", {7'd0, done_s[0]}, 8'd0);
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      chk("midrst.nodone", {6'd0, done_s[0], busy_s[0]}, 8'd0);
    end
    $display("scan midrst dut0 aborted by reset, tt=%b pass=%b", tt_s[0], pass_s[0]);
    run_scan(0, 4'b1110, 4'b1110, 4'b1110, 1'b1, 1'b0, -1, "after_rst");
    @(posedge clk); #1;

    // SETTLE_CYCLES=1, then a second scan started in the done cycle.
    run_scan(1, 4'b1110, 4'b1110, 4'b1110, 1'b1, 1'b0, -1, "s1_or");
    run_scan(1, 4'b1000, 4'b1110, 4'b1000, 1'b0, 1'b0, -1, "s1_restart_and");
    @(posedge clk); #1;

    // Random gate functions with gate_in corrupted outside SAMPLE cycles.
    for (int i = 0; i < 16; i++) begin
      d   = i % 2;
      fn  = 4'($urandom);
      exp = ($urandom_range(0, 1) == 1) ? fn : 4'($urandom);
      run_scan(d, fn, exp, fn, (fn == exp), 1'b1, int'($urandom_range(1, 12)), "rand");
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
